// File: rtl/sfu_pkg.sv
// Shared types and lane helpers for the SFU accumulation stage.
// Words are COL lanes of signed PSUM_BW bits, lane i at [i*PSUM_BW +: PSUM_BW].
package sfu_pkg;
  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 16;
  localparam int ROW_W   = $clog2(DEPTH);
  localparam int NROWS_W = ROW_W + 1;
  localparam int WORD_W  = COL * PSUM_BW;

  typedef logic [WORD_W-1:0]         word_t;
  typedef logic signed [PSUM_BW-1:0] lane_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic lane_t get_lane(word_t w, int i);
    return lane_t'(w[i*PSUM_BW +: PSUM_BW]);
  endfunction

  function automatic word_t set_lane(word_t w, int i, lane_t v);
    word_t r = w;
    r[i*PSUM_BW +: PSUM_BW] = v;
    return r;
  endfunction

  function automatic lane_t relu_lane(lane_t v, logic en);
    return (en && v[PSUM_BW-1]) ? '0 : v;
  endfunction

  // Lane-wise add; each lane wraps modulo 2^PSUM_BW.
  function automatic word_t add_word(word_t a, word_t b);
    word_t r = '0;
    for (int i = 0; i < COL; i++) begin
      r = set_lane(r, i, get_lane(a, i) + get_lane(b, i));
    end
    return r;
  endfunction

  function automatic word_t relu_word(word_t w, logic en);
    word_t r = '0;
    for (int i = 0; i < COL; i++) begin
      r = set_lane(r, i, relu_lane(get_lane(w, i), en));
    end
    return r;
  endfunction
endpackage

// File: rtl/psum_acc_bank.sv
// Per-row accumulator register file: one read-modify-write port, one flush read port.
// Contents are never cleared; the first pass of a tile overwrites.
module psum_acc_bank
  import sfu_pkg::*;
(
  input  logic              clk,
  input  logic              acc_en,
  input  logic              acc_add,
  input  logic [ROW_W-1:0]  acc_addr,
  input  logic [WORD_W-1:0] acc_in,
  input  logic [ROW_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem [DEPTH];

  // Read side of the add is the registered array, so a write at one edge is
  // already visible to the add in the very next cycle (nrows=1 case).
  always_ff @(posedge clk) begin
    if (acc_en) begin
      mem[acc_addr] <= acc_add ? add_word(mem[acc_addr], acc_in) : acc_in;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sfu_accum.sv
// Drains PSUM words from the output FIFO, accumulates them across kernel passes
// into a per-row bank, then flushes rows (optionally ReLU'd) to the output SRAM.
module sfu_accum
  import sfu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         cfg_npass,
  input  logic [NROWS_W-1:0] cfg_nrows,
  input  logic               cfg_relu,
  input  logic               fifo_valid,
  output logic               fifo_rd,
  input  logic [WORD_W-1:0]  fifo_data,
  output logic               out_wr,
  output logic [ROW_W-1:0]   out_addr,
  output logic [WORD_W-1:0]  out_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         fsm_state
);
  // Upstream handshake: a word transfers on every rising edge where fifo_rd is
  // high; fifo_rd is fifo_valid gated by DRAIN, so no pop without valid data.
  state_t             state_q, state_d;
  logic [3:0]         pass_q, npass_q, npass_n;
  logic [ROW_W-1:0]   row_q;
  logic [NROWS_W-1:0] nrows_q, nrows_n;
  logic               relu_q;
  logic               pop, accept, last_row, last_pass;
  logic [WORD_W-1:0]  rd_data;

  assign last_row  = ({1'b0, row_q} == (nrows_q - NROWS_W'(1)));
  assign last_pass = (pass_q == (npass_q - 4'd1));
  // done_q keeps busy high for the DONE pulse cycle, so start waits until after.
  assign accept    = start && !done;

  always_comb begin
    npass_n = (cfg_npass == 4'd0) ? 4'd1 : cfg_npass;
    if (cfg_nrows == '0)                      nrows_n = NROWS_W'(1);
    else if (cfg_nrows > NROWS_W'(DEPTH))     nrows_n = NROWS_W'(DEPTH);
    else                                      nrows_n = cfg_nrows;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && last_row && last_pass) state_d = ST_FLUSH;
      ST_FLUSH: if (last_row) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop       = (state_q == ST_DRAIN) && fifo_valid;
    fifo_rd   = pop;
    busy      = (state_q != ST_IDLE) || done;
    fsm_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q  <= '0;
      row_q   <= '0;
      npass_q <= '0;
      nrows_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          npass_q <= npass_n;
          nrows_q <= nrows_n;
          relu_q  <= cfg_relu;
          pass_q  <= '0;
          row_q   <= '0;
        end
        ST_DRAIN: if (pop) begin
          if (last_row) begin
            row_q  <= '0;
            pass_q <= last_pass ? 4'd0 : pass_q + 4'd1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        ST_FLUSH: row_q <= last_row ? '0 : row_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      done     <= 1'b0;
    end else begin
      out_wr <= (state_q == ST_FLUSH);
      done   <= (state_q == ST_DONE);
      if (state_q == ST_FLUSH) begin
        out_addr <= row_q;
        out_data <= relu_word(rd_data, relu_q);
      end
    end
  end

  psum_acc_bank u_bank (
    .clk      (clk),
    .acc_en   (pop),
    .acc_add  (pass_q != 4'd0),
    .acc_addr (row_q),
    .acc_in   (fifo_data),
    .rd_addr  (row_q),
    .rd_data  (rd_data)
  );
endmodule

// File: tb/tb_sfu_accum.sv
// Directed bench for sfu_accum: hand-computed tiles, timing and reset-abort checks.
module tb_sfu_accum;
  import sfu_pkg::*;

  logic         clk = 1'b0;
  logic         reset, start, cfg_relu, fifo_valid, fifo_rd, out_wr, busy, done;
  logic [3:0]   cfg_npass;
  logic [4:0]   cfg_nrows;
  logic [127:0] fifo_data, out_data;
  logic [3:0]   out_addr;
  logic [1:0]   fsm_state;

  sfu_accum dut (
    .clk(clk), .reset(reset), .start(start), .cfg_npass(cfg_npass),
    .cfg_nrows(cfg_nrows), .cfg_relu(cfg_relu), .fifo_valid(fifo_valid),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .out_wr(out_wr),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  logic [127:0] wr_log [16];
  int wr_cnt, pop_cnt, bad_rd, order_err, first_pop_cyc, last_pop_cyc, last_wr_cyc, start_cyc;
  logic [127:0] feed_w[$];

  // Monitor samples between the driver (negedge+1) and the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (fifo_rd) begin
      if (pop_cnt == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pop_cnt++;
      if (!fifo_valid) bad_rd++;
    end
    if (out_wr) begin
      wr_log[out_addr] = out_data;
      if (out_addr != 4'(wr_cnt)) order_err++;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk2(input int base, input int step);
    logic [127:0] w = '0;
    for (int i = 0; i < 8; i++) w[i*16 +: 16] = 16'(base + step * i);
    return w;
  endfunction

  function automatic logic [127:0] alt(input int even_v, input int odd_v);
    logic [127:0] w = '0;
    for (int i = 0; i < 8; i++) w[i*16 +: 16] = (i % 2 == 0) ? 16'(even_v) : 16'(odd_v);
    return w;
  endfunction

  task automatic clear_mon();
    wr_cnt = 0; pop_cnt = 0; bad_rd = 0; order_err = 0;
    first_pop_cyc = -1; last_pop_cyc = -1; last_wr_cyc = -1;
    for (int i = 0; i < 16; i++) wr_log[i] = '0;
  endtask

  task automatic do_start(input int np, input int nr, input logic relu);
    @(negedge clk);
    cfg_npass = 4'(np);
    cfg_nrows = 5'(nr);
    cfg_relu  = relu;
    start     = 1'b1;
    start_cyc = cyc;
  endtask

  // mode 0: words offered every cycle; mode 1: valid pattern 1,0,0,1 repeating.
  task automatic feed(input int mode);
    int idx = 0;
    int k = 0;
    while (idx < feed_w.size() && k < 200) begin
      @(negedge clk);
      start = 1'b0;
      fifo_valid = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      fifo_data  = feed_w[idx];
      #1;
      if (fifo_rd) idx++;
      k++;
    end
    @(negedge clk);
    start = 1'b0;
    fifo_valid = 1'b0;
    fifo_data = '0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < 100);
    check({tag, " done seen"}, done, 1);
    check({tag, " done one cycle after last write"}, cyc - last_wr_cyc, 1);
    check({tag, " busy during done"}, busy, 1);
    @(negedge clk);
    #1;
    check({tag, " busy low after done"}, busy, 0);
    check({tag, " done single cycle"}, done, 0);
  endtask

  task automatic common(input string tag, input int pops, input int writes);
    check({tag, " pop count"}, pop_cnt, pops);
    check({tag, " write count"}, wr_cnt, writes);
    check({tag, " pops without valid"}, bad_rd, 0);
    check({tag, " write address order"}, order_err, 0);
  endtask

  initial begin
    int pc;
    reset = 1'b1; start = 1'b0; cfg_npass = '0; cfg_nrows = '0; cfg_relu = 1'b0;
    fifo_valid = 1'b0; fifo_data = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    check("reset fifo_rd", fifo_rd, 0);
    check("reset out_wr", out_wr, 0);
    check("reset out_addr", out_addr, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset state", fsm_state, 0);
    reset = 1'b0;

    // Single pass, four distinct rows, continuous valid.
    clear_mon();
    feed_w = '{mk2(1, 1), mk2(11, 1), mk2(21, 1), mk2(31, 1)};
    do_start(1, 4, 1'b0);
    feed(0);
    wait_done("t1");
    common("t1", 4, 4);
    check("t1 first pop latency", first_pop_cyc - start_cyc, 1);
    check("t1 pops back to back", last_pop_cyc - first_pop_cyc, 3);
    check("t1 row0", wr_log[0], mk2(1, 1));
    check("t1 row1", wr_log[1], mk2(11, 1));
    check("t1 row2", wr_log[2], mk2(21, 1));
    check("t1 row3", wr_log[3], mk2(31, 1));

    // Three passes of 5 over two rows.
    clear_mon();
    feed_w = '{mk2(5, 0), mk2(5, 0), mk2(5, 0), mk2(5, 0), mk2(5, 0), mk2(5, 0)};
    do_start(3, 2, 1'b0);
    feed(0);
    wait_done("t2");
    common("t2", 6, 2);
    check("t2 row0", wr_log[0], mk2(15, 0));
    check("t2 row1", wr_log[1], mk2(15, 0));

    // ReLU on and off with mixed-sign lanes.
    clear_mon();
    feed_w = '{alt(-7, 9)};
    do_start(1, 1, 1'b1);
    feed(0);
    wait_done("t3r");
    common("t3r", 1, 1);
    check("t3 relu on", wr_log[0], alt(0, 9));
    clear_mon();
    feed_w = '{alt(-7, 9)};
    do_start(1, 1, 1'b0);
    feed(0);
    wait_done("t3n");
    check("t3 relu off", wr_log[0], alt(-7, 9));

    // Gated valid, two passes over three rows.
    clear_mon();
    feed_w = '{mk2(1, 1), mk2(100, 1), mk2(-50, 1), mk2(3, 1), mk2(-200, 1), mk2(7, 1)};
    do_start(2, 3, 1'b0);
    feed(1);
    wait_done("t4");
    common("t4", 6, 3);
    check("t4 row0", wr_log[0], mk2(4, 2));
    check("t4 row1", wr_log[1], mk2(-100, 2));
    check("t4 row2", wr_log[2], mk2(-43, 2));

    // Wrap-around on nrows=1 (consecutive pops hit the same row).
    clear_mon();
    feed_w = '{mk2(32767, -1), mk2(1, 0)};
    do_start(2, 1, 1'b0);
    feed(0);
    wait_done("t5");
    common("t5", 2, 1);
    check("t5 wrap word", wr_log[0], mk2(32768, -1));
    check("t5 lane0 wraps to 8000", wr_log[0][15:0], 16'h8000);

    // Zero config means one pass of one row.
    clear_mon();
    feed_w = '{mk2(-5, 3)};
    do_start(0, 0, 1'b0);
    feed(0);
    wait_done("t6");
    common("t6", 1, 1);
    check("t6 row0", wr_log[0], mk2(-5, 3));

    // nrows above depth clamps to 16 rows.
    clear_mon();
    feed_w.delete();
    for (int r = 0; r < 16; r++) feed_w.push_back(mk2(r * 10, 1));
    do_start(1, 20, 1'b1);
    feed(0);
    wait_done("t7");
    common("t7", 16, 16);
    check("t7 row0", wr_log[0], mk2(0, 1));
    check("t7 row15", wr_log[15], mk2(150, 1));

    // Abort mid-drain with reset, then a fresh nrows=1 tile.
    clear_mon();
    do_start(2, 4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      fifo_valid = 1'b1;
      fifo_data = mk2(100 * k + 1000, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort fifo_rd", fifo_rd, 0);
    check("abort out_wr", out_wr, 0);
    check("abort busy", busy, 0);
    check("abort out_data", out_data, 0);
    reset = 1'b0;
    pc = pop_cnt;
    repeat (3) @(negedge clk);
    #1;
    check("abort no further pops", pop_cnt, pc);
    check("abort no writes", wr_cnt, 0);
    fifo_valid = 1'b0;
    clear_mon();
    feed_w = '{mk2(10, 0), mk2(-3, 0), mk2(20, 0)};
    do_start(3, 1, 1'b0);
    feed(0);
    wait_done("t8");
    common("t8", 3, 1);
    check("t8 row0 after abort", wr_log[0], mk2(27, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
